control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Microcoded control unit for the 8-bit bus CPU.
- Holds the micro-step counter (T0..T4) and decodes opcode, step and flags into the 16-bit control word that drives the registers, PC, RAM, ALU and output register.
- Supports free-run and single-step modes, and latches halt.
- Purely a sequencer: owns no bus, drives no datapath data.

Parameters:
- HALT_ON_ILLEGAL, 0, when 1 an undefined opcode halts the CPU at its T2; when 0 it executes as NOP.

Ports:
- i_clk  input  1  system clock, all state updates on rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_instr  input  8  instruction register contents; opcode = i_instr[7:4].
- i_flag_c  input  1  latched ALU carry flag (external flags register).
- i_flag_z  input  1  latched ALU zero flag.
- i_run  input  1  global enable; 0 freezes sequencing.
- i_step_mode  input  1  1 = single-step micro-steps on i_step_pulse rising edges.
- i_step_pulse  input  1  step request (level, edge-detected internally).
- o_ctrl  output  16  control word: bit0 AI, 1 AO, 2 BI, 3 BO, 4 II, 5 IO, 6 OI, 7 MI, 8 RI, 9 RO, 10 J, 11 CO, 12 CE, 13 EO, 14 SU, 15 FI.
- o_step  output  3  current micro-step, 0..4.
- o_last  output  1  high during final micro-step of the current instruction.
- o_halted  output  1  halt latched.
- o_illegal  output  1  high during T2 of an undefined opcode.

Behaviour:
- Reset (i_rst=1 at edge): step=0, halted=0, step_pulse_q=0. Combinationally in the reset state o_ctrl=0, o_last=0, o_illegal=0, o_step=0. i_rst takes priority over everything, including halt and mid-instruction.
- adv = i_run & ~halted & (~i_step_mode | (i_step_pulse & ~step_pulse_q)). step_pulse_q <= i_step_pulse every cycle.
- o_ctrl = microcode(opcode, step, flags) when adv=1, else 0. A stalled step never re-asserts loads or CE.
- On an edge with adv=1: step <= o_last ? 0 : step+1. No idle steps after the last step. Steps T5..T7 are unreachable.
- Fetch, all opcodes:
  - T0: CO|MI.
  - T1: RO|II|CE.
  - Opcode is decoded from i_instr starting at T2.
- Execute (step: word; last step marked *):
  - NOP 0000: T2 0*.
  - LDA 0001: T2 IO|MI; T3 RO|AI*.
  - ADD 0010: T2 IO|MI; T3 RO|BI; T4 EO|AI|FI*.
  - SUB 0011: as ADD, with T4 EO|SU|AI|FI*.
  - STA 0100: T2 IO|MI; T3 AO|RI*.
  - LDI 0101: T2 IO|AI*.
  - JMP 0110: T2 IO|J*.
  - JC 0111: T2 (i_flag_c ? IO|J : 0)*.
  - JZ 1000: T2 (i_flag_z ? IO|J : 0)*.
  - OUT 1110: T2 AO|OI*.
  - HLT 1111: T2 0*; halted <= 1 on that edge.
  - Others: T2 0*, o_illegal=1. If HALT_ON_ILLEGAL=1, halted <= 1 on that edge.
- Conditional jumps sample flags combinationally during T2 of the same cycle. A not-taken jump still consumes T2.
- Halted: step is held at 0, o_ctrl=0, o_last=0. Only i_rst clears halt. i_run and step pulses are ignored.
- i_run=0 mid-instruction: step is held and resumes at the same step when i_run returns to 1.
- Single-step: each rising edge of i_step_pulse advances exactly one micro-step. A level held high advances only once. Switching i_step_mode mid-instruction is legal and takes effect the next cycle.
- o_last is asserted only when adv=1.

Test Plan:
- Reset then i_run=1, i_instr=0x5A (LDI): successive cycles o_ctrl = 0x0880, 0x1210, 0x0021 with o_last=1 in the third; step returns to 0 the next cycle.
- i_instr=0x2E (ADD) free-run: T2 0x00A0, T3 0x0204, T4 0xA001 with o_last=1. With i_instr=0x3E (SUB), T4 = 0xE001.
- JC with i_flag_c=0 → T2 o_ctrl=0, o_last=1. With i_flag_c=1 → T2 0x0420. JZ checked the same way against i_flag_z.
- HLT (0xF0): after T2, o_halted=1 and o_ctrl stays 0 for 20 cycles despite i_run=1. Asserting i_rst for one cycle gives o_halted=0, step=0.
- Single-step: i_step_mode=1, i_step_pulse held high for 5 cycles → exactly one advance (o_ctrl nonzero for one cycle only). Three separate pulses → o_step reaches 3.
- Illegal opcode 0x9x: o_illegal=1 at T2. HALT_ON_ILLEGAL=0 → fetch continues. HALT_ON_ILLEGAL=1 → o_halted=1. i_rst asserted during step 3 of ADD → step=0 next cycle with no o_ctrl.

Source files
------------

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcoded control sequencer for the 8-bit bus CPU
module control_sequencer #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_instr,
    input  logic        i_flag_c,
    input  logic        i_flag_z,
    input  logic        i_run,
    input  logic        i_step_mode,
    input  logic        i_step_pulse,
    output logic [15:0] o_ctrl,
    output logic [2:0]  o_step,
    output logic        o_last,
    output logic        o_halted,
    output logic        o_illegal
);

    // Control word bit assignments
    localparam logic [15:0] C_AI = 16'h0001;
    localparam logic [15:0] C_AO = 16'h0002;
    localparam logic [15:0] C_BI = 16'h0004;
    localparam logic [15:0] C_II = 16'h0010;
    localparam logic [15:0] C_IO = 16'h0020;
    localparam logic [15:0] C_OI = 16'h0040;
    localparam logic [15:0] C_MI = 16'h0080;
    localparam logic [15:0] C_RI = 16'h0100;
    localparam logic [15:0] C_RO = 16'h0200;
    localparam logic [15:0] C_J  = 16'h0400;
    localparam logic [15:0] C_CO = 16'h0800;
    localparam logic [15:0] C_CE = 16'h1000;
    localparam logic [15:0] C_EO = 16'h2000;
    localparam logic [15:0] C_SU = 16'h4000;
    localparam logic [15:0] C_FI = 16'h8000;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    step_t       step;
    logic        halted;
    logic        step_pulse_q;

    logic [3:0]  opcode;
    logic        adv;
    logic [15:0] ctrl_word;
    logic        last_word;
    logic        undefined_op;
    logic        halt_req;
    logic        unused_operand;

    assign opcode         = i_instr[7:4];
    assign unused_operand = ^i_instr[3:0];

    // Advance qualifier: run enabled, not halted, and either free-running or a fresh step edge
    assign adv = ~i_rst & i_run & ~halted
               & (~i_step_mode | (i_step_pulse & ~step_pulse_q));

    // Microcode ROM: decode opcode, step and flags into the raw control word
    always_comb begin
        ctrl_word    = '0;
        last_word    = 1'b0;
        undefined_op = 1'b0;
        case (step)
            T0: ctrl_word = C_CO | C_MI;
            T1: ctrl_word = C_RO | C_II | C_CE;
            T2: begin
                case (opcode)
                    OP_NOP: last_word = 1'b1;
                    OP_LDA: ctrl_word = C_IO | C_MI;
                    OP_ADD: ctrl_word = C_IO | C_MI;
                    OP_SUB: ctrl_word = C_IO | C_MI;
                    OP_STA: ctrl_word = C_IO | C_MI;
                    OP_LDI: begin
                        ctrl_word = C_IO | C_AI;
                        last_word = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl_word = C_IO | C_J;
                        last_word = 1'b1;
                    end
                    OP_JC: begin
                        ctrl_word = i_flag_c ? (C_IO | C_J) : 16'h0000;
                        last_word = 1'b1;
                    end
                    OP_JZ: begin
                        ctrl_word = i_flag_z ? (C_IO | C_J) : 16'h0000;
                        last_word = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl_word = C_AO | C_OI;
                        last_word = 1'b1;
                    end
                    OP_HLT: last_word = 1'b1;
                    default: begin
                        undefined_op = 1'b1;
                        last_word    = 1'b1;
                    end
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl_word = C_RO | C_AI;
                        last_word = 1'b1;
                    end
                    OP_ADD: ctrl_word = C_RO | C_BI;
                    OP_SUB: ctrl_word = C_RO | C_BI;
                    OP_STA: begin
                        ctrl_word = C_AO | C_RI;
                        last_word = 1'b1;
                    end
                    default: last_word = 1'b1;
                endcase
            end
            T4: begin
                last_word = 1'b1;
                case (opcode)
                    OP_ADD:  ctrl_word = C_EO | C_AI | C_FI;
                    OP_SUB:  ctrl_word = C_EO | C_SU | C_AI | C_FI;
                    default: ctrl_word = '0;
                endcase
            end
            default: last_word = 1'b1;
        endcase
    end

    // Halt is requested by HLT at T2, or by an undefined opcode when configured to trap
    assign halt_req = (step == T2)
                    & ((opcode == OP_HLT) | (undefined_op & HALT_ON_ILLEGAL));

    // A stalled step presents an all-zero word so no load or CE repeats
    assign o_ctrl    = adv ? ctrl_word : 16'h0000;
    assign o_last    = adv & last_word;
    assign o_illegal = adv & undefined_op;
    assign o_step    = step;
    assign o_halted  = halted;

    // Step counter, halt latch and step-pulse edge history
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            step         <= T0;
            halted       <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            step_pulse_q <= i_step_pulse;
            if (adv) begin
                step <= last_word ? T0 : step_t'(step + 3'd1);
                if (halt_req) begin
                    halted <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_a, run_a, rst_b, run_b;
    logic [7:0]  instr;
    logic        flag_c, flag_z, step_mode, step_pulse;
    logic [15:0] ctrl_a, ctrl_b;
    logic [2:0]  step_a, step_b;
    logic        last_a, last_b, halted_a, halted_b, ill_a, ill_b;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    control_sequencer #(.HALT_ON_ILLEGAL(1'b0)) dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_instr(instr),
        .i_flag_c(flag_c), .i_flag_z(flag_z), .i_run(run_a),
        .i_step_mode(step_mode), .i_step_pulse(step_pulse),
        .o_ctrl(ctrl_a), .o_step(step_a), .o_last(last_a),
        .o_halted(halted_a), .o_illegal(ill_a)
    );

    control_sequencer #(.HALT_ON_ILLEGAL(1'b1)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_instr(instr),
        .i_flag_c(flag_c), .i_flag_z(flag_z), .i_run(run_b),
        .i_step_mode(step_mode), .i_step_pulse(step_pulse),
        .o_ctrl(ctrl_b), .o_step(step_b), .o_last(last_b),
        .o_halted(halted_b), .o_illegal(ill_b)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full instruction on dut_a from T0, n execute steps with words e2..e4; ends at next T0
    task automatic fetch_exec(input string tag, input logic [7:0] ins, input int n,
                              input logic [15:0] e2, input logic [15:0] e3,
                              input logic [15:0] e4);
        logic [15:0] e;
        instr = ins;
        #1;
        chk({tag, " T0 ctrl"}, ctrl_a, 16'h0880);
        chk({tag, " T0 step"}, {13'd0, step_a}, 16'd0);
        chk({tag, " T0 last"}, {15'd0, last_a}, 16'd0);
        cyc();
        chk({tag, " T1 ctrl"}, ctrl_a, 16'h1210);
        for (int k = 0; k < n; k++) begin
            cyc();
            e = (k == 0) ? e2 : ((k == 1) ? e3 : e4);
            chk({tag, $sformatf(" T%0d ctrl", k + 2)}, ctrl_a, e);
            chk({tag, $sformatf(" T%0d step", k + 2)}, {13'd0, step_a}, 16'(k + 2));
            chk({tag, $sformatf(" T%0d last", k + 2)}, {15'd0, last_a}, (k == n - 1) ? 16'd1 : 16'd0);
            chk({tag, $sformatf(" T%0d illegal", k + 2)}, {15'd0, ill_a}, 16'd0);
        end
        cyc();
    endtask

    initial begin
        rst_a = 1'b1; run_a = 1'b1; rst_b = 1'b1; run_b = 1'b1;
        instr = 8'h5A; flag_c = 1'b0; flag_z = 1'b0;
        step_mode = 1'b0; step_pulse = 1'b0;

        // Reset state, outputs quiet even with run asserted
        cyc();
        chk("reset ctrl", ctrl_a, 16'h0000);
        chk("reset step", {13'd0, step_a}, 16'd0);
        chk("reset last", {15'd0, last_a}, 16'd0);
        chk("reset illegal", {15'd0, ill_a}, 16'd0);
        chk("reset halted", {15'd0, halted_a}, 16'd0);
        rst_a = 1'b0;

        // Free-running instruction set
        fetch_exec("LDI", 8'h5A, 1, 16'h0021, 16'h0000, 16'h0000);
        fetch_exec("ADD", 8'h2E, 3, 16'h00A0, 16'h0204, 16'hA001);
        fetch_exec("SUB", 8'h3E, 3, 16'h00A0, 16'h0204, 16'hE001);
        fetch_exec("LDA", 8'h1C, 2, 16'h00A0, 16'h0201, 16'h0000);
        fetch_exec("STA", 8'h4D, 2, 16'h00A0, 16'h0102, 16'h0000);
        fetch_exec("JMP", 8'h63, 1, 16'h0420, 16'h0000, 16'h0000);
        fetch_exec("OUT", 8'hE0, 1, 16'h0042, 16'h0000, 16'h0000);
        fetch_exec("NOP", 8'h00, 1, 16'h0000, 16'h0000, 16'h0000);
        flag_c = 1'b0; flag_z = 1'b1;
        fetch_exec("JC nc", 8'h74, 1, 16'h0000, 16'h0000, 16'h0000);
        flag_c = 1'b1; flag_z = 1'b0;
        fetch_exec("JC c", 8'h74, 1, 16'h0420, 16'h0000, 16'h0000);
        fetch_exec("JZ nz", 8'h85, 1, 16'h0000, 16'h0000, 16'h0000);
        flag_c = 1'b0; flag_z = 1'b1;
        fetch_exec("JZ z", 8'h85, 1, 16'h0420, 16'h0000, 16'h0000);
        flag_z = 1'b0;

        // Run drop mid-instruction holds the step and resumes it
        instr = 8'h2E;
        cyc(); cyc(); cyc();
        run_a = 1'b0;
        #1;
        chk("stall ctrl", ctrl_a, 16'h0000);
        chk("stall last", {15'd0, last_a}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall hold step", {13'd0, step_a}, 16'd3);
            chk("stall hold ctrl", ctrl_a, 16'h0000);
        end
        run_a = 1'b1;
        #1;
        chk("resume T3 ctrl", ctrl_a, 16'h0204);
        cyc();
        chk("resume T4 ctrl", ctrl_a, 16'hA001);
        chk("resume T4 last", {15'd0, last_a}, 16'd1);
        cyc();
        chk("resume wrap step", {13'd0, step_a}, 16'd0);

        // Reset during T3 of ADD
        cyc(); cyc(); cyc();
        chk("pre-reset step", {13'd0, step_a}, 16'd3);
        rst_a = 1'b1;
        #1;
        chk("mid reset ctrl", ctrl_a, 16'h0000);
        cyc();
        rst_a = 1'b0; run_a = 1'b0;
        #1;
        chk("post reset step", {13'd0, step_a}, 16'd0);
        chk("post reset ctrl", ctrl_a, 16'h0000);
        run_a = 1'b1;

        // HLT latches and ignores run and step pulses until reset
        fetch_exec("HLT", 8'hF0, 1, 16'h0000, 16'h0000, 16'h0000);
        chk("halt latched", {15'd0, halted_a}, 16'd1);
        for (int i = 0; i < 20; i++) begin
            step_pulse = ~step_pulse;
            #1;
            chk("halt ctrl", ctrl_a, 16'h0000);
            chk("halt step", {13'd0, step_a}, 16'd0);
            chk("halt last", {15'd0, last_a}, 16'd0);
            cyc();
        end
        chk("halt still", {15'd0, halted_a}, 16'd1);
        step_pulse = 1'b0;
        rst_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        #1;
        chk("unhalt halted", {15'd0, halted_a}, 16'd0);
        chk("unhalt step", {13'd0, step_a}, 16'd0);

        // Single-step: held level advances once, separate pulses advance once each
        step_mode = 1'b1; instr = 8'h2E;
        #1;
        chk("ss idle ctrl", ctrl_a, 16'h0000);
        cyc();
        chk("ss idle step", {13'd0, step_a}, 16'd0);
        step_pulse = 1'b1;
        #1;
        chk("ss first ctrl", ctrl_a, 16'h0880);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("ss held ctrl", ctrl_a, 16'h0000);
            chk("ss held step", {13'd0, step_a}, 16'd1);
            cyc();
        end
        step_pulse = 1'b0;
        #1;
        chk("ss low ctrl", ctrl_a, 16'h0000);
        cyc();
        step_pulse = 1'b1;
        #1;
        chk("ss pulse2 ctrl", ctrl_a, 16'h1210);
        cyc();
        step_pulse = 1'b0;
        cyc();
        step_pulse = 1'b1;
        #1;
        chk("ss pulse3 ctrl", ctrl_a, 16'h00A0);
        cyc();
        step_pulse = 1'b0;
        #1;
        chk("ss step 3", {13'd0, step_a}, 16'd3);
        chk("ss wait ctrl", ctrl_a, 16'h0000);
        step_mode = 1'b0;
        #1;
        chk("ss->run T3 ctrl", ctrl_a, 16'h0204);
        cyc();
        chk("ss->run T4 ctrl", ctrl_a, 16'hA001);
        cyc();
        chk("ss->run wrap", {13'd0, step_a}, 16'd0);

        // Illegal opcode: dut_a continues fetching, dut_b halts
        instr = 8'h9C; rst_b = 1'b0;
        #1;
        chk("ill b T0 ctrl", ctrl_b, 16'h0880);
        cyc(); cyc();
        chk("ill a flag", {15'd0, ill_a}, 16'd1);
        chk("ill b flag", {15'd0, ill_b}, 16'd1);
        chk("ill a ctrl", ctrl_a, 16'h0000);
        chk("ill a last", {15'd0, last_a}, 16'd1);
        cyc();
        chk("ill a halted", {15'd0, halted_a}, 16'd0);
        chk("ill a refetch", ctrl_a, 16'h0880);
        chk("ill b halted", {15'd0, halted_b}, 16'd1);
        chk("ill b ctrl", ctrl_b, 16'h0000);
        cyc();
        chk("ill a T1", ctrl_a, 16'h1210);
        chk("ill b stay", ctrl_b, 16'h0000);
        chk("ill b step", {13'd0, step_b}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
